// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the MEM-stage load/store controller.
//   size_e    - access size encoding (byte, half, word; 2'b11 behaves as word)
//   state_e   - controller FSM states
//   op_t      - captured request (write, size, unsigned, byte offset, wdata)
//   is_misaligned / is_subword - request classification helpers
// Compile-time option used by the controller: DMEM_MISALIGN_TRAP_EN.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE     = 2'b00,
        SZ_HALF     = 2'b01,
        SZ_WORD     = 2'b10,
        SZ_WORD_ALT = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_e;

    typedef struct packed {
        logic        write;
        size_e       size;
        logic        unsigned_ld;
        logic [1:0]  off;
        logic [31:0] wdata;
    } op_t;

    // Halves must sit on an even byte, words on a word boundary.
    function automatic logic is_misaligned(size_e size, logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    function automatic logic is_subword(size_e size);
        return (size == SZ_BYTE) || (size == SZ_HALF);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational lane logic shared by loads and stores.
//   word_i     - memory word (load source, or old word for a store merge)
//   wdata_i    - right-aligned store data
//   size_i     - access size
//   off_i      - byte offset inside the word
//   unsigned_i - zero-extend (1) or sign-extend (0) load data
//   load_o     - extracted and extended load value
//   merge_o    - word_i with the addressed lanes replaced by wdata_i
// Half accesses only look at off_i[1] and word accesses ignore off_i, so a
// misaligned request that reaches here is silently aligned down.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  size_e       size_i,
    input  logic [1:0]  off_i,
    input  logic        unsigned_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = 8'(word_i >> {off_i, 3'b000});
        lane_h = off_i[1] ? word_i[31:16] : word_i[15:0];
        case (size_i)
            SZ_BYTE: load_o = {{24{~unsigned_i & lane_b[7]}}, lane_b};
            SZ_HALF: load_o = {{16{~unsigned_i & lane_h[15]}}, lane_h};
            default: load_o = word_i;
        endcase
    end

    always_comb begin
        merge_o = word_i;
        case (size_i)
            SZ_BYTE: merge_o[{off_i, 3'b000} +: 8]     = wdata_i[7:0];
            SZ_HALF: merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: merge_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// dmem_lsu_ctrl: load/store controller between the MEM stage and a
// word-organised data memory (combinational read, write on clock edge).
//   clk, rst            - clock, asynchronous active-high reset
//   req_*               - MEM-stage request (byte address, size, data)
//   stall               - high while a sub-word store merges its old word
//   rsp_valid/rdata/err - one-cycle completion pulse with load data
//   mem_*               - word-address memory port
// Sub-word stores are a read (accept cycle) followed by a merged write
// (MERGE cycle). Optional misalignment trapping: DMEM_MISALIGN_TRAP_EN.
module dmem_lsu_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata
);

    state_e            state_q, state_d;
    op_t               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       merge_q;
    logic              rsp_valid_q, rsp_err_q;
    logic [31:0]       rsp_rdata_q;

    size_e       req_sz;
    logic        accept, trap, go, sub_store;
    logic        in_merge;
    logic [31:0] al_load, al_merge;

    assign req_sz    = size_e'(req_size);
    assign in_merge  = (state_q == ST_MERGE);
    assign accept    = req_valid && !in_merge;
    assign sub_store = req_write && is_subword(req_sz);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap = is_misaligned(req_sz, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    // A trapped access still completes (with rsp_err) but never touches memory.
    assign go = accept && !trap;

    // In MERGE the lane logic works on the captured request and old word;
    // otherwise it looks straight at the live request and memory output.
    dmem_lane_align u_align (
        .word_i     (in_merge ? merge_q     : mem_rdata),
        .wdata_i    (in_merge ? op_q.wdata  : req_wdata),
        .size_i     (in_merge ? op_q.size   : req_sz),
        .off_i      (in_merge ? op_q.off    : req_addr[1:0]),
        .unsigned_i (in_merge ? op_q.unsigned_ld : req_unsigned),
        .load_o     (al_load),
        .merge_o    (al_merge)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (go && sub_store) state_d = ST_MERGE;
            ST_MERGE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_addr = req_addr[ADDR_W+1:2];
        mem_wd   = req_wdata;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        stall    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    if (!req_write || sub_store) mem_re = 1'b1;
                    else                         mem_we = 1'b1;
                end
            end
            ST_MERGE: begin
                mem_addr = addr_q;
                mem_wd   = al_merge;
                mem_we   = op_q.write;
                stall    = 1'b1;
            end
            default: ;
        endcase
        // Keep the memory untouched while reset is asserted mid-cycle.
        if (rst) begin
            mem_we = 1'b0;
            mem_re = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= '0;
            addr_q      <= '0;
            merge_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            if (accept) begin
                op_q.write       <= req_write;
                op_q.size        <= req_sz;
                op_q.unsigned_ld <= req_unsigned;
                op_q.off         <= req_addr[1:0];
                op_q.wdata       <= req_wdata;
                addr_q           <= req_addr[ADDR_W+1:2];
            end
            if (go && sub_store) merge_q <= mem_rdata;
            if (go && !req_write) rsp_rdata_q <= al_load;
            // Sub-word stores respond after their MERGE cycle, everything else
            // (including trapped accesses) one cycle after accept.
            rsp_valid_q <= (accept && (trap || !sub_store)) || in_merge;
            rsp_err_q   <= accept && trap;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// tb_dmem_lsu_ctrl: self-checking bench for dmem_lsu_ctrl. A behavioural
// memory model tracks what every accepted request must do; one compare
// process checks the DUT against it every cycle, and directed scenarios pin
// the model with hand-computed literals. Honours DMEM_MISALIGN_TRAP_EN.
module tb_dmem_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [11:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        stall, rsp_valid, rsp_err, mem_we, mem_re;
    logic [31:0] rsp_rdata, mem_wd, mem_rdata;
    logic [9:0]  mem_addr;

    logic [31:0] physMem [1024];
    logic [31:0] refMem  [1024];
    int          physWrites = 0;
    int          expWrites  = 0;
    int          rspPulses  = 0;
    int          checkCount = 0;
    int          passCount  = 0;

    // Reference model state.
    bit          merging = 1'b0;
    logic [9:0]  mAddr = '0;
    logic [31:0] mWord = '0;
    logic        expRspValid = 1'b0;
    logic        expRspErr = 1'b0;
    logic [31:0] expRdata = '0;

    dmem_lsu_ctrl #(.ADDR_W(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Physical memory: combinational read, write on the clock edge.
    assign mem_rdata = physMem[mem_addr];
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            physMem[mem_addr] = mem_wd;
            physWrites++;
        end
    end

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) rspPulses++;
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checkCount++;
        if (got === want) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic modelTrap(logic [1:0] sz, logic [1:0] off);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return off[0];
        return off != 2'd0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] modelLoad(logic [31:0] w, logic [1:0] off, logic [1:0] sz, logic uns);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (w >> (8 * (off & 2'd2))) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] modelMerge(logic [31:0] old, logic [31:0] wd, logic [1:0] off, logic [1:0] sz);
        logic [31:0] mask;
        int sh;
        if (sz == 2'd0) begin
            sh = 8 * off;
            mask = 32'hFF << sh;
        end else begin
            sh = 8 * (off & 2'd2);
            mask = 32'hFFFF << sh;
        end
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            merging     = 1'b0;
            expRspValid = 1'b0;
            expRspErr   = 1'b0;
            expRdata    = '0;
        end else begin
            expRspValid = 1'b0;
            expRspErr   = 1'b0;
            if (merging) begin
                refMem[mAddr] = mWord;
                expWrites++;
                expRspValid = 1'b1;
                merging = 1'b0;
            end else if (req_valid) begin
                if (modelTrap(req_size, req_addr[1:0])) begin
                    expRspValid = 1'b1;
                    expRspErr   = 1'b1;
                end else if (!req_write) begin
                    expRdata = modelLoad(refMem[req_addr[11:2]], req_addr[1:0], req_size, req_unsigned);
                    expRspValid = 1'b1;
                end else if (req_size >= 2'd2) begin
                    refMem[req_addr[11:2]] = req_wdata;
                    expWrites++;
                    expRspValid = 1'b1;
                end else begin
                    mAddr = req_addr[11:2];
                    mWord = modelMerge(refMem[req_addr[11:2]], req_wdata, req_addr[1:0], req_size);
                    merging = 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always begin
        logic expWe, expRe;
        @(negedge clk);
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(expRspValid));
        checkOutput("rsp_err",   32'(rsp_err),   32'(expRspErr));
        checkOutput("rsp_rdata", rsp_rdata,      expRdata);
        checkOutput("stall",     32'(stall),     32'(merging));
        #3;
        expWe = 1'b0;
        expRe = 1'b0;
        if (!rst) begin
            if (merging) expWe = 1'b1;
            else if (req_valid && !modelTrap(req_size, req_addr[1:0])) begin
                if (!req_write || req_size < 2'd2) expRe = 1'b1;
                else expWe = 1'b1;
            end
        end
        checkOutput("mem_we", 32'(mem_we), 32'(expWe));
        checkOutput("mem_re", 32'(mem_re), 32'(expRe));
        if (!rst && merging) begin
            checkOutput("merge_addr", 32'(mem_addr), 32'(mAddr));
            checkOutput("merge_wd",   mem_wd,        mWord);
        end else if (expWe || expRe) begin
            checkOutput("mem_addr", 32'(mem_addr), 32'(req_addr[11:2]));
            if (expWe) checkOutput("mem_wd", mem_wd, req_wdata);
        end
    end

    // ---------------- stimulus ----------------
    // Presents a request and returns just before the edge that accepts it;
    // the request is held while the controller is merging.
    task automatic applyStimulus(input logic wr, input logic [11:0] addr, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] wd);
        int guard;
        @(negedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_addr = addr;
        req_size = sz; req_unsigned = uns; req_wdata = wd;
        guard = 0;
        while (merging && guard < 8) begin
            @(negedge clk); #1;
            guard++;
        end
        if (merging) begin
            checkCount++;
            $display("[TB] FAIL accept_timeout: still merging after %0d cycles, expected acceptance", guard);
        end
    endtask

    task automatic idleCycle();
        @(negedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wBase, pBase;
        logic [31:0] oldWord;
        for (int i = 0; i < 1024; i++) begin
            oldWord = $urandom;
            physMem[i] = oldWord;
            refMem[i]  = oldWord;
        end
        physMem[5] = 32'h8877_6655;
        refMem[5]  = 32'h8877_6655;

        // Reset values.
        @(negedge clk); @(negedge clk); #1;
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("rst_stall", 32'(stall), 32'h0);
        rst = 1'b0;

        // Loads from word 5.
        applyStimulus(1'b0, 12'h015, 2'd0, 1'b0, 32'h0);
        idleCycle();
        checkOutput("ld_byte_valid", 32'(rsp_valid), 32'h1);
        checkOutput("ld_byte_s", rsp_rdata, 32'h0000_0066);
        applyStimulus(1'b0, 12'h016, 2'd1, 1'b0, 32'h0);
        idleCycle();
        checkOutput("ld_half_s", rsp_rdata, 32'hFFFF_8877);
        applyStimulus(1'b0, 12'h016, 2'd1, 1'b1, 32'h0);
        idleCycle();
        checkOutput("ld_half_u", rsp_rdata, 32'h0000_8877);

        // Byte store read-modify-write.
        applyStimulus(1'b1, 12'h017, 2'd0, 1'b0, 32'h0000_00AB);
        idleCycle();
        checkOutput("sb_stall_a1", 32'(stall), 32'h1);
        checkOutput("sb_valid_a1", 32'(rsp_valid), 32'h0);
        idleCycle();
        checkOutput("sb_stall_a2", 32'(stall), 32'h0);
        checkOutput("sb_valid_a2", 32'(rsp_valid), 32'h1);
        checkOutput("sb_word5", physMem[5], 32'hAB77_6655);
        checkOutput("sb_rdata_kept", rsp_rdata, 32'h0000_8877);

        // Word store then back-to-back load.
        applyStimulus(1'b1, 12'h020, 2'd2, 1'b0, 32'h1234_5678);
        applyStimulus(1'b0, 12'h020, 2'd2, 1'b0, 32'h0);
        checkOutput("sw_no_stall", 32'(stall), 32'h0);
        idleCycle();
        checkOutput("sw_ld_back", rsp_rdata, 32'h1234_5678);

        // Held request across MERGE: one write, one pulse per request.
        idleCycle(); idleCycle();
        wBase = physWrites;
        pBase = rspPulses;
        applyStimulus(1'b1, 12'h00A, 2'd1, 1'b0, 32'h0000_1234);
        applyStimulus(1'b0, 12'h008, 2'd2, 1'b0, 32'h0);
        idleCycle(); idleCycle();
        checkOutput("hold_writes", 32'(physWrites - wBase), 32'd1);
        checkOutput("hold_pulses", 32'(rspPulses - pBase), 32'd2);
        checkOutput("hold_merged_hi", {16'h0, physMem[2][31:16]}, 32'h0000_1234);

        // Reset in the middle of a half-store MERGE.
        oldWord = physMem[9];
        applyStimulus(1'b1, 12'h026, 2'd1, 1'b0, 32'h0000_BEEF);
        @(posedge clk); #2;
        rst = 1'b1;
        req_valid = 1'b0;
        #1;
        checkOutput("mrst_mem_we", 32'(mem_we), 32'h0);
        checkOutput("mrst_stall", 32'(stall), 32'h0);
        checkOutput("mrst_valid", 32'(rsp_valid), 32'h0);
        checkOutput("mrst_rdata", rsp_rdata, 32'h0);
        @(negedge clk); @(negedge clk); #1;
        checkOutput("mrst_word9", physMem[9], oldWord);
        rst = 1'b0;

        // Misaligned word store at 0x21.
        oldWord = physMem[8];
        applyStimulus(1'b1, 12'h021, 2'd2, 1'b0, 32'hCAFE_F00D);
        idleCycle();
`ifdef DMEM_MISALIGN_TRAP_EN
        checkOutput("mis_err", 32'(rsp_err), 32'h1);
        checkOutput("mis_word8", physMem[8], oldWord);
`else
        checkOutput("mis_err", 32'(rsp_err), 32'h0);
        checkOutput("mis_word8", physMem[8], 32'hCAFE_F00D);
`endif

        // Randomized traffic over a small address window.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idleCycle();
            else applyStimulus(1'($urandom_range(0, 1)), 12'($urandom_range(0, 63)),
                               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
        end
        idleCycle(); idleCycle(); idleCycle();

        for (int i = 0; i < 16; i++) checkOutput("final_mem", physMem[i], refMem[i]);
        checkOutput("write_count", 32'(physWrites), 32'(expWrites));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
